// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port byte-enable block RAM and its read pipeline.
package bram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data/valid register chain for one RAM port; depth equals the read latency.
module bram_rd_pipe
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] stage_data  [READ_LATENCY];
    logic                  stage_valid [READ_LATENCY];

    // Data stages only load behind a valid bit, so data_out holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_data[i]  <= '0;
                stage_valid[i] <= 1'b0;
            end
        end else begin
            stage_valid[0] <= rd_en;
            if (rd_en) begin
                stage_data[0] <= rd_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    assign data_out = stage_data[READ_LATENCY-1];
    assign valid    = stage_valid[READ_LATENCY-1];

endmodule

// File: rtl/bram_dp_be.sv
// True dual-port block RAM with byte-lane writes, registered reads, collision
// rules and a post-reset clear sweep.
module bram_dp_be
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADD_WIDTH      = 10,
    parameter int RAM_SIZE       = 1 << ADD_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              busy,

    input  logic                              a_cs,
    input  logic                              a_we,
    input  logic                              a_oe,
    input  logic [be_width(DATA_WIDTH)-1:0]   a_be,
    input  logic [ADD_WIDTH-1:0]              a_add,
    input  logic [DATA_WIDTH-1:0]             a_data_in,
    output logic [DATA_WIDTH-1:0]             a_data_out,
    output logic                              a_valid,

    input  logic                              b_cs,
    input  logic                              b_we,
    input  logic                              b_oe,
    input  logic [be_width(DATA_WIDTH)-1:0]   b_be,
    input  logic [ADD_WIDTH-1:0]              b_add,
    input  logic [DATA_WIDTH-1:0]             b_data_in,
    output logic [DATA_WIDTH-1:0]             b_data_out,
    output logic                              b_valid
);

    localparam int                   BE_WIDTH = be_width(DATA_WIDTH);
    localparam logic [ADD_WIDTH:0]   SIZE_W   = (ADD_WIDTH + 1)'(RAM_SIZE);
    localparam logic [ADD_WIDTH-1:0] LAST_ADD = ADD_WIDTH'(RAM_SIZE - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    clr_state_t            state;
    logic [ADD_WIDTH-1:0]  ptr;

    logic                  a_in_range, b_in_range;
    logic                  a_wr, b_wr, a_rd, b_rd;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic [DATA_WIDTH-1:0] a_rd_word, b_rd_word;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign busy = (state == CLEAR);

    assign a_in_range = {1'b0, a_add} < SIZE_W;
    assign b_in_range = {1'b0, b_add} < SIZE_W;

    assign a_wr = a_cs & a_we & ~busy & a_in_range;
    assign b_wr = b_cs & b_we & ~busy & b_in_range;
    assign a_rd = a_cs & a_oe & ~busy;
    assign b_rd = b_cs & b_oe & ~busy;

    // Reads see the array before this edge's writes land, so cross-port reads
    // always get old data; only a port's own write can be merged in.
    assign a_old = a_in_range ? mem[a_add] : '0;
    assign b_old = b_in_range ? mem[b_add] : '0;

    assign a_rd_word = (RDW_MODE == RDW_NEW && a_wr) ? merge_lanes(a_old, a_data_in, a_be) : a_old;
    assign b_rd_word = (RDW_MODE == RDW_NEW && b_wr) ? merge_lanes(b_old, b_data_in, b_be) : b_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_ADD) begin
                state <= IDLE;
            end
        end
    end

    // NOTE: the array has no reset branch so it maps onto block RAM; zeroing is
    // done by the clear sweep one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            // Port A is applied last so it wins lanes both ports enable.
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (b_wr && b_be[i]) begin
                    mem[b_add][8*i +: 8] <= b_data_in[8*i +: 8];
                end
            end
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (a_wr && a_be[i]) begin
                    mem[a_add][8*i +: 8] <= a_data_in[8*i +: 8];
                end
            end
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_a_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (a_rd),
        .rd_data  (a_rd_word),
        .data_out (a_data_out),
        .valid    (a_valid)
    );

    bram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_b_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (b_rd),
        .rd_data  (b_rd_word),
        .data_out (b_data_out),
        .valid    (b_valid)
    );

endmodule

// File: tb/tb_bram_dp_be.sv
// Directed bench: instance 0 uses defaults; instance 1 uses latency 2, new-data
// read-during-write and a 1000-word array. Both share the same stimulus.
module tb_bram_dp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cs, a_we, a_oe, b_cs, b_we, b_oe;
    logic [3:0]  a_be, b_be;
    logic [9:0]  a_add, b_add;
    logic [31:0] a_data_in, b_data_in;

    logic        busy0, a_v0, b_v0, busy1, a_v1, b_v1;
    logic [31:0] a_do0, b_do0, a_do1, b_do1;

    int total = 0;
    int bad   = 0;
    int n0, n1, vs, it;

    always #5 clk = ~clk;

    bram_dp_be u_dut0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .a_cs(a_cs), .a_we(a_we), .a_oe(a_oe), .a_be(a_be), .a_add(a_add),
        .a_data_in(a_data_in), .a_data_out(a_do0), .a_valid(a_v0),
        .b_cs(b_cs), .b_we(b_we), .b_oe(b_oe), .b_be(b_be), .b_add(b_add),
        .b_data_in(b_data_in), .b_data_out(b_do0), .b_valid(b_v0)
    );

    bram_dp_be #(
        .RAM_SIZE(1000), .READ_LATENCY(2), .RDW_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .a_cs(a_cs), .a_we(a_we), .a_oe(a_oe), .a_be(a_be), .a_add(a_add),
        .a_data_in(a_data_in), .a_data_out(a_do1), .a_valid(a_v1),
        .b_cs(b_cs), .b_we(b_we), .b_oe(b_oe), .b_be(b_be), .b_add(b_add),
        .b_data_in(b_data_in), .b_data_out(b_do1), .b_valid(b_v1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic cs, input logic we, input logic oe, input logic [3:0] be,
                         input logic [9:0] add, input logic [31:0] d);
        a_cs = cs; a_we = we; a_oe = oe; a_be = be; a_add = add; a_data_in = d;
    endtask

    task automatic set_b(input logic cs, input logic we, input logic oe, input logic [3:0] be,
                         input logic [9:0] add, input logic [31:0] d);
        b_cs = cs; b_we = we; b_oe = oe; b_be = be; b_add = add; b_data_in = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        set_b(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
    endtask

    // Single-cycle read: instance 0 answers after one edge, instance 1 after two.
    task automatic read_a(input logic [9:0] add, input logic [31:0] e0, input logic [31:0] e1,
                          input string tag);
        set_a(1'b1, 1'b0, 1'b1, 4'h0, add, 32'h0);
        tick();
        set_a(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        check({tag, " a_v0"}, 32'(a_v0), 32'd1);
        check({tag, " a_do0"}, a_do0, e0);
        check({tag, " a_v1 early"}, 32'(a_v1), 32'd0);
        tick();
        check({tag, " a_v0 pulse"}, 32'(a_v0), 32'd0);
        check({tag, " a_do0 hold"}, a_do0, e0);
        check({tag, " a_v1"}, 32'(a_v1), 32'd1);
        check({tag, " a_do1"}, a_do1, e1);
        tick();
        check({tag, " a_v1 pulse"}, 32'(a_v1), 32'd0);
    endtask

    task automatic read_b(input logic [9:0] add, input logic [31:0] e0, input logic [31:0] e1,
                          input string tag);
        set_b(1'b1, 1'b0, 1'b1, 4'h0, add, 32'h0);
        tick();
        set_b(1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        check({tag, " b_v0"}, 32'(b_v0), 32'd1);
        check({tag, " b_do0"}, b_do0, e0);
        check({tag, " b_v1 early"}, 32'(b_v1), 32'd0);
        tick();
        check({tag, " b_v0 pulse"}, 32'(b_v0), 32'd0);
        check({tag, " b_v1"}, 32'(b_v1), 32'd1);
        check({tag, " b_do1"}, b_do1, e1);
        tick();
        check({tag, " b_v1 pulse"}, 32'(b_v1), 32'd0);
    endtask

    // Counts busy cycles of both instances until both finish; a request is
    // injected mid-sweep and must produce no valid and no write.
    task automatic sweep(input string tag);
        n0 = 0; n1 = 0; vs = 0; it = 0;
        while ((busy0 || busy1) && it < 3000) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (a_v0 || a_v1 || b_v0 || b_v1) vs++;
            if (it == 100) begin
                set_a(1'b1, 1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF);
                set_b(1'b1, 1'b1, 1'b1, 4'hF, 10'h006, 32'hCAFEF00D);
            end else begin
                idle();
            end
            tick();
            it++;
        end
        idle();
        check({tag, " busy0 cycles"}, 32'(n0), 32'd1024);
        check({tag, " busy1 cycles"}, 32'(n1), 32'd1000);
        check({tag, " valid while busy"}, 32'(vs), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        check("rst busy0", 32'(busy0), 32'd1);
        check("rst busy1", 32'(busy1), 32'd1);
        check("rst a_v0", 32'(a_v0), 32'd0);
        check("rst a_do0", a_do0, 32'h0);
        check("rst b_v0", 32'(b_v0), 32'd0);
        check("rst b_do0", b_do0, 32'h0);
        check("rst a_v1", 32'(a_v1), 32'd0);
        check("rst b_do1", b_do1, 32'h0);
        rst = 1'b0;
        sweep("sweep1");

        read_a(10'h000, 32'h0, 32'h0, "clr 000");
        read_a(10'h3FF, 32'h0, 32'h0, "clr 3ff");
        read_a(10'h1EF, 32'h0, 32'h0, "clr 1ef");
        read_a(10'h005, 32'h0, 32'h0, "busy wr a");
        read_b(10'h006, 32'h0, 32'h0, "busy wr b");

        // Byte-lane update of one word.
        set_a(1'b1, 1'b1, 1'b0, 4'hF, 10'h00A, 32'h67890ACD);
        tick();
        set_a(1'b1, 1'b1, 1'b0, 4'b0101, 10'h00A, 32'hFFFFFFFF);
        tick();
        idle();
        check("write no valid", 32'(a_v0), 32'd0);
        read_a(10'h00A, 32'h67FF0AFF, 32'h67FF0AFF, "be");

        // Concurrent writes, then back-to-back reads on A.
        set_a(1'b1, 1'b1, 1'b0, 4'hF, 10'h049, 32'h360C6AB8);
        set_b(1'b1, 1'b1, 1'b0, 4'hF, 10'h288, 32'h247BB76C);
        tick();
        idle();
        set_a(1'b1, 1'b0, 1'b1, 4'h0, 10'h288, 32'h0);
        tick();
        set_a(1'b1, 1'b0, 1'b1, 4'h0, 10'h049, 32'h0);
        check("b2b1 a_v0", 32'(a_v0), 32'd1);
        check("b2b1 a_do0", a_do0, 32'h247BB76C);
        tick();
        idle();
        check("b2b2 a_v0", 32'(a_v0), 32'd1);
        check("b2b2 a_do0", a_do0, 32'h360C6AB8);
        check("b2b1 a_v1", 32'(a_v1), 32'd1);
        check("b2b1 a_do1", a_do1, 32'h247BB76C);
        tick();
        check("b2b end a_v0", 32'(a_v0), 32'd0);
        check("b2b2 a_v1", 32'(a_v1), 32'd1);
        check("b2b2 a_do1", a_do1, 32'h360C6AB8);
        tick();
        check("b2b end a_v1", 32'(a_v1), 32'd0);

        // Same-address collision with a B read in the same cycle.
        set_a(1'b1, 1'b1, 1'b0, 4'hF, 10'h285, 32'h11223344);
        tick();
        set_a(1'b1, 1'b1, 1'b0, 4'b0011, 10'h285, 32'h0000AAAA);
        set_b(1'b1, 1'b1, 1'b1, 4'hF, 10'h285, 32'hBBBBBBBB);
        tick();
        idle();
        check("coll b_v0", 32'(b_v0), 32'd1);
        check("coll b_do0 old", b_do0, 32'h11223344);
        tick();
        check("coll b_v1", 32'(b_v1), 32'd1);
        check("coll b_do1 own new", b_do1, 32'hBBBBBBBB);
        tick();
        read_a(10'h285, 32'hBBBBAAAA, 32'hBBBBAAAA, "coll merge");

        // Same-port read-during-write.
        set_a(1'b1, 1'b1, 1'b1, 4'hF, 10'h1EF, 32'h00000017);
        tick();
        idle();
        check("rdw a_v0", 32'(a_v0), 32'd1);
        check("rdw a_do0 old", a_do0, 32'h0);
        tick();
        check("rdw a_v1", 32'(a_v1), 32'd1);
        check("rdw a_do1 new", a_do1, 32'h00000017);
        tick();
        read_a(10'h1EF, 32'h00000017, 32'h00000017, "rdw after");

        // Chip select low masks everything.
        set_a(1'b0, 1'b1, 1'b1, 4'hF, 10'h00A, 32'h0);
        set_b(1'b0, 1'b1, 1'b1, 4'hF, 10'h049, 32'h0);
        tick();
        idle();
        check("cs0 a_v0", 32'(a_v0), 32'd0);
        check("cs0 b_v0", 32'(b_v0), 32'd0);
        tick();
        check("cs0 a_v1", 32'(a_v1), 32'd0);
        check("cs0 b_v1", 32'(b_v1), 32'd0);
        read_a(10'h00A, 32'h67FF0AFF, 32'h67FF0AFF, "cs0 a");
        read_b(10'h049, 32'h360C6AB8, 32'h360C6AB8, "cs0 b");

        // 0x3E8 is in range for instance 0, out of range for instance 1.
        set_b(1'b1, 1'b1, 1'b0, 4'hF, 10'h3E8, 32'h12345678);
        tick();
        idle();
        read_b(10'h3E8, 32'h12345678, 32'h0, "oor");

        // Reset in the middle of the sweep restarts it from zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2 busy0", 32'(busy0), 32'd1);
        repeat (500) tick();
        check("mid busy0", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep("sweep2");
        read_b(10'h049, 32'h0, 32'h0, "reclr 049");
        read_a(10'h3E8, 32'h0, 32'h0, "reclr 3e8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Parametrised true dual-port block RAM. Successor to the single-port cs/we/oe `ram`.
- Adds the following:
  - two independent ports A and B
  - byte-lane write enables
  - configurable registered read latency with a valid strobe
  - defined read-during-write and write-collision rules
  - a post-reset memory clear sweep
- Sits as the shared weight/activation store between the BDPU datapath and the host loader.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADD_WIDTH, 10: address width per port.
- RAM_SIZE, 1<<ADD_WIDTH: number of words; must be ≤ 2^ADD_WIDTH.
- READ_LATENCY, 1: cycles from the read request edge to data_out/valid; legal values are 1 or 2.
- RDW_MODE, 0: same-port read-during-write result. 0 = old data; 1 = new (merged) data.
- CLEAR_ON_RESET, 1: 1 = sweep zeros into every word after reset; 0 = no sweep, contents undefined.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- busy, output, 1: high while the clear sweep runs.
- a_cs, input, 1: port A select.
- a_we, input, 1: port A write request (qualified by a_cs).
- a_oe, input, 1: port A read request (qualified by a_cs).
- a_be, input, DATA_WIDTH/8: port A byte enables; bit i covers bits [8i+7:8i].
- a_add, input, ADD_WIDTH: port A address.
- a_data_in, input, DATA_WIDTH: port A write data.
- a_data_out, output, DATA_WIDTH: port A read data.
- a_valid, output, 1: port A read data valid (one-cycle pulse per read).
- b_cs, b_we, b_oe, b_be, b_add, b_data_in, b_data_out, b_valid: port B, same as port A.

Behaviour:
- Reset values: a_data_out = b_data_out = 0, a_valid = b_valid = 0, all read pipeline stages cleared. busy = 1 if CLEAR_ON_RESET, else 0.
- Clear FSM states: IDLE, CLEAR.
  - rst → CLEAR with ptr = 0 (if CLEAR_ON_RESET=0, rst → IDLE).
  - In CLEAR, each cycle writes 0 to mem[ptr] and increments ptr.
  - ptr == RAM_SIZE-1 → IDLE on the next edge. The sweep takes exactly RAM_SIZE cycles after rst deasserts.
  - busy = (state == CLEAR).
  - rst asserted mid-sweep restarts at ptr = 0.
- While busy, all port requests are ignored: no write, no valid.
- Write: on an edge with cs & we & !busy, each lane i with be[i] = 1 is updated from data_in. Lanes with be[i] = 0 are untouched. be = 0 is a no-op write.
- Read: on an edge with cs & oe & !busy, the address is sampled.
  - READ_LATENCY=1: data_out and valid are updated at that edge, visible in the following cycle.
  - READ_LATENCY=2: one additional register stage.
  - valid pulses for exactly one cycle per read. data_out holds its last value when no read occurs.
- we and oe both set on the same port in one cycle: write and read both happen.
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the byte-merged new word.
- Cross-port read of an address being written by the other port in the same cycle always returns old data.
- Both ports write the same address in the same cycle: port A wins on lanes where both a_be and b_be are set. B-only lanes take B data.
- Address ≥ RAM_SIZE: write is dropped. Read returns 0 with valid asserted.
- cs = 0 masks we and oe entirely.
- Back-to-back reads every cycle are sustained: full throughput, no bubbles, at either latency.

Decomposition:
- Shared package bram_pkg holds:
  - RDW_OLD = 0, RDW_NEW = 1
  - clear-FSM state encodings IDLE = 1'b0, CLEAR = 1'b1
  - the BE_WIDTH = DATA_WIDTH/8 derivation helper
- One natural sub-module: bram_rd_pipe. Instantiated once per port, it holds:
  - the READ_LATENCY-deep data/valid register chain
  - its reset
- The memory array, collision logic and clear FSM stay in bram_dp_be.

Test Plan:
- Clear sweep (defaults): deassert rst → busy high for exactly 1024 cycles. Then read addresses 0x000, 0x3FF, 0x1EF → 0 each, valid one cycle after the request.
- Byte enables: A writes 0x67890ACD to 0x0A with be = 4'b1111, then 0xFFFFFFFF with be = 4'b0101. A reads 0x0A → 0x67FF0AFF, with a_valid timing per READ_LATENCY (run with 1 and 2).
- Dual-port concurrency and throughput: A writes 0x360C6AB8 @ 0x049 while B writes 0x247BB76C @ 0x288. Next cycles, A reads 0x288 then 0x049 back-to-back → 0x247BB76C, 0x360C6AB8 on consecutive cycles, valid high both cycles.
- Collision and read-during-write:
  - Same cycle: A writes 0x0000AAAA @ 0x285 with be 0011, B writes 0xBBBBBBBB @ 0x285 with be 1111, B also reads 0x285 → B read returns the prior value. A later read returns 0xBBBBAAAA.
  - With RDW_MODE=1, a same-port write+read of 0x0000_0017 @ 0x1EF returns 0x00000017.
- Reset and masking:
  - Assert rst mid-sweep at ptr = 500 → busy restarts for a full 1024 cycles.
  - Request issued while busy → no valid, memory unchanged.
  - cs = 0 with we = 1 → no write.
  - Out-of-range address with RAM_SIZE = 1000: read of 0x3E8 → 0 with valid; a write to 0x3E8 is dropped.
